note_sequencer: RTL and testbench

// - Plays a short song held in an internal table of DEPTH entries.
// - Each entry gives: note, octave, volume, rest flag and duration.
// - Steps through the table on a tempo tick.
// - Drives the note/octave/volume inputs of the square-wave tone generator, which

---
 rtl/note_sequencer.sv | 153 +++++++++++++++
 tb/tb_note_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Table-driven note sequencer: steps through DEPTH song entries on a tempo tick
// and drives note/octave/volume of the downstream square-wave tone generator.
module note_sequencer #(
    parameter int DEPTH     = 16,
    parameter int GAP_TICKS = 1,
    localparam int IW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_addr,
    input  logic [19:0]   wr_data,
    input  logic [4:0]    len,
    input  logic [15:0]   tempo_div,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
    output logic [3:0]    note,
    output logic [2:0]    octave,
    output logic [7:0]    volume,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] cur_idx
);

    localparam int GAP_LAST = (GAP_TICKS > 0) ? GAP_TICKS - 1 : 0;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP, S_DONE} state_t;

    logic [19:0]   mem [DEPTH];
    logic [19:0]   rd_reg;

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [15:0]   cnt_reg, cnt_next;
    logic [15:0]   beat_reg, beat_next;
    logic [3:0]    dur_reg, dur_next;
    logic [3:0]    note_reg, note_next;
    logic [2:0]    octave_reg, octave_next;
    logic [7:0]    volume_reg, volume_next;

    logic [31:0]   len_eff;
    logic          tick;
    logic          last_entry;
    logic          state_change;
    state_t        adv_state;
    logic [IW-1:0] adv_idx;

    assign len_eff      = (32'(len) > 32'(DEPTH)) ? 32'(DEPTH) : 32'(len);
    assign tick         = (cnt_reg >= tempo_div);
    assign last_entry   = (32'(idx_reg) + 32'd1) >= len_eff;
    assign state_change = (state_next != state_reg);

    // Advance target: next entry, wrap to 0 when looping, else finish.
    assign adv_state = (!last_entry || loop_en) ? S_FETCH : S_DONE;
    assign adv_idx   = !last_entry ? idx_reg + 1'b1 : (loop_en ? '0 : idx_reg);

    // Read address follows idx_next so the entry is already in rd_reg during FETCH.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_reg <= mem[idx_next];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            beat_reg   <= '0;
            dur_reg    <= '0;
            note_reg   <= '0;
            octave_reg <= '0;
            volume_reg <= '0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            cnt_reg    <= cnt_next;
            beat_reg   <= beat_next;
            dur_reg    <= dur_next;
            note_reg   <= note_next;
            octave_reg <= octave_next;
            volume_reg <= volume_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            S_IDLE: begin
                if (start && !stop && len_eff != 32'd0) begin
                    state_next = S_FETCH;
                    idx_next   = '0;
                end
            end
            S_FETCH: state_next = S_PLAY;
            S_PLAY: begin
                if (tick && beat_reg == 16'(dur_reg)) begin
                    if (GAP_TICKS > 0) begin
                        state_next = S_GAP;
                    end else begin
                        state_next = adv_state;
                        idx_next   = adv_idx;
                    end
                end
            end
            S_GAP: begin
                if (tick && 32'(beat_reg) == 32'(GAP_LAST)) begin
                    state_next = adv_state;
                    idx_next   = adv_idx;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (stop && state_reg != S_IDLE) begin
            state_next = S_IDLE;
            idx_next   = idx_reg;
        end
    end

    always_comb begin
        cnt_next    = (state_change || tick) ? 16'd0 : cnt_reg + 16'd1;
        beat_next   = state_change ? 16'd0 : (tick ? beat_reg + 16'd1 : beat_reg);
        dur_next    = dur_reg;
        note_next   = note_reg;
        octave_next = octave_reg;
        volume_next = volume_reg;
        if (state_reg == S_FETCH && state_next == S_PLAY) begin
            dur_next = rd_reg[19:16];
            // Rests and out-of-range notes keep the last pitch and just go silent.
            if (rd_reg[15] || rd_reg[14:11] >= 4'd12) begin
                volume_next = 8'd0;
            end else begin
                note_next   = rd_reg[14:11];
                octave_next = rd_reg[10:8];
                volume_next = rd_reg[7:0];
            end
        end else if (state_next != S_PLAY && state_next != S_FETCH) begin
            volume_next = 8'd0;
        end
    end

    assign note    = note_reg;
    assign octave  = octave_reg;
    assign volume  = volume_reg;
    assign busy    = (state_reg != S_IDLE);
    assign done    = (state_reg == S_DONE);
    assign cur_idx = idx_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: per-cycle scoreboard of expected
// outputs, a table of song vectors, and hand-written corner-case sequences.
module tb_note_sequencer;

    localparam int GAP = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [19:0] wr_data;
    logic [4:0]  len;
    logic [15:0] tempo_div;
    logic        loop_en;
    logic        start;
    logic        stop;
    logic [3:0]  note;
    logic [2:0]  octave;
    logic [7:0]  volume;
    logic        busy;
    logic        done;
    logic [3:0]  cur_idx;

    note_sequencer #(.DEPTH(16), .GAP_TICKS(GAP)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .tempo_div(tempo_div), .loop_en(loop_en), .start(start), .stop(stop),
        .note(note), .octave(octave), .volume(volume), .busy(busy), .done(done),
        .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] note;
        logic [2:0] octave;
        logic       oct_chk;
        logic [7:0] volume;
        logic       busy;
        logic       done;
        logic [3:0] idx;
        logic       idx_chk;
    } exp_t;

    typedef struct {
        int len;
        int td;
        int n_exp;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [19:0] tb_mem [16];
    logic [3:0]  cur_note;
    logic [7:0]  cur_vol;
    int          checks = 0;
    int          errors = 0;

    function automatic void push(logic [3:0] n, logic [2:0] o, logic oc, logic [7:0] v,
                                 logic b, logic d, logic [3:0] i, logic ic);
        exp_t e;
        e.note = n; e.octave = o; e.oct_chk = oc; e.volume = v;
        e.busy = b; e.done = d; e.idx = i; e.idx_chk = ic;
        sb.push_back(e);
    endfunction

    // Expand a song into its per-cycle output timeline, starting with the start cycle.
    task automatic expect_song(input int n, input int td);
        logic [19:0] d;
        logic        silent;
        push(cur_note, 3'd0, 1'b0, cur_vol, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < n; i++) begin
            d = tb_mem[i];
            push(cur_note, 3'd0, 1'b0, cur_vol, 1'b1, 1'b0, 4'(i), 1'b1);
            silent = d[15] || (d[14:11] >= 4'd12);
            if (!silent) cur_note = d[14:11];
            cur_vol = silent ? 8'd0 : d[7:0];
            repeat ((int'(d[19:16]) + 1) * (td + 1))
                push(cur_note, d[10:8], !silent, cur_vol, 1'b1, 1'b0, 4'(i), 1'b1);
            cur_vol = 8'd0;
            repeat (GAP * (td + 1))
                push(cur_note, 3'd0, 1'b0, 8'd0, 1'b1, 1'b0, 4'(i), 1'b1);
        end
        push(cur_note, 3'd0, 1'b0, 8'd0, 1'b1, 1'b1, 4'(n - 1), 1'b1);
        push(cur_note, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (note !== mon_e.note || volume !== mon_e.volume || busy !== mon_e.busy ||
                done !== mon_e.done || (mon_e.idx_chk && cur_idx !== mon_e.idx) ||
                (mon_e.oct_chk && octave !== mon_e.octave)) begin
                errors++;
                $display("FAIL sb t=%0t got note=%0d oct=%0d vol=%0d busy=%0d done=%0d idx=%0d want note=%0d oct=%0d vol=%0d busy=%0d done=%0d idx=%0d",
                         $time, note, octave, volume, busy, done, cur_idx, mon_e.note,
                         mon_e.octave, mon_e.volume, mon_e.busy, mon_e.done, mon_e.idx);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic write_entry(input int addr, input logic [19:0] data);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = 4'(addr); wr_data = data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Push the expected timeline and pulse start in the same cycle.
    task automatic go(input int n, input int td);
        @(posedge clk); #1;
        if (n == 0) begin
            repeat (6) push(cur_note, 3'd0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        end else begin
            expect_song(n, td);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_sb();
        for (int c = 0; c < 4000 && sb.size() > 0; c++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_timeout remaining=%0d want=0", sb.size());
            sb.delete();
        end
        $display("song done, checks so far %0d", checks);
    endtask

    vec_t        vt [4];
    logic [19:0] w;
    logic [3:0]  seq [5];
    int          got_n;
    logic        saw_done;

    initial begin
        vt[0] = '{len: 2,  td: 3, n_exp: 2};
        vt[1] = '{len: 4,  td: 1, n_exp: 4};
        vt[2] = '{len: 0,  td: 2, n_exp: 0};
        vt[3] = '{len: 20, td: 0, n_exp: 16};

        reset = 1'b0; start = 1'b1; stop = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        len = 5'd2; tempo_div = 16'd0; loop_en = 1'b0;
        cur_note = 4'd0; cur_vol = 8'd0;

        repeat (2) begin
            @(negedge clk);
            check("rst_outputs", int'({note, octave, volume, done, cur_idx}), 0);
            check("rst_busy", int'(busy), 0);
        end
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", int'(busy), 0);

        tb_mem[0] = {4'd1, 1'b0, 4'd0,  3'd2, 8'd40};
        tb_mem[1] = {4'd0, 1'b0, 4'd4,  3'd2, 8'd40};
        tb_mem[2] = {4'd1, 1'b1, 4'd5,  3'd3, 8'd50};
        tb_mem[3] = {4'd0, 1'b0, 4'd13, 3'd1, 8'd60};
        for (int i = 4; i < 16; i++)
            tb_mem[i] = {4'(i % 3), 1'b0, 4'(i % 12), 3'(i % 8), 8'(i * 7 + 3)};
        for (int i = 0; i < 16; i++) write_entry(i, tb_mem[i]);

        for (int v = 0; v < 4; v++) begin
            len = 5'(vt[v].len);
            tempo_div = 16'(vt[v].td);
            go(vt[v].n_exp, vt[v].td);
            wait_sb();
        end

        // Looping over three entries, then abort.
        len = 5'd3; tempo_div = 16'd0; loop_en = 1'b1;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        got_n = 0; saw_done = 1'b0;
        for (int c = 0; c < 300 && got_n < 5; c++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
            if (busy && (got_n == 0 || cur_idx != seq[got_n - 1])) begin
                seq[got_n] = cur_idx;
                got_n++;
            end
        end
        check("loop_count", got_n, 5);
        check("loop_idx0", int'(seq[0]), 0);
        check("loop_idx1", int'(seq[1]), 1);
        check("loop_idx2", int'(seq[2]), 2);
        check("loop_idx3", int'(seq[3]), 0);
        check("loop_idx4", int'(seq[4]), 1);
        check("loop_no_done", int'(saw_done), 0);
        @(posedge clk); #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        @(negedge clk);
        check("stop_busy", int'(busy), 0);
        check("stop_volume", int'(volume), 0);
        check("stop_note", int'(note), 4);
        @(negedge clk);
        check("stop_no_done", int'(done), 0);
        loop_en = 1'b0;
        cur_note = 4'd4;

        // Write to entry 0 in the same cycle it is fetched: old data plays.
        len = 5'd1; tempo_div = 16'd0;
        w = {4'd0, 1'b0, 4'd9, 3'd5, 8'd77};
        go(1, 0);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = w;
        @(posedge clk); #1;
        wr_en = 1'b0;
        wait_sb();
        tb_mem[0] = w;
        go(1, 0);
        wait_sb();

        // Rewrite entry 1 while entry 0 plays, and a stray start mid-song.
        len = 5'd2; tempo_div = 16'd2;
        w = {4'd0, 1'b0, 4'd7, 3'd4, 8'd99};
        tb_mem[1] = w;
        go(2, 2);
        write_entry(1, w);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_sb();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
